// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the mux select arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_idx_t;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning from ptr
// upward, wrapping modulo N_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_idx_t         ptr,
  output logic             any,
  output sel_idx_t         idx
);

  // Scan offsets 0..N_REQ-1 from ptr; the first hit wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      sel_idx_t cand;
      cand = ptr + sel_idx_t'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 3-bit select of the shared 8:1 bit mux.
// Grants one owner at a time, hands over with no dead cycle, and forcibly
// releases an owner after MAX_HOLD consecutive cycles.
//
// Request/release protocol: req[i] is a level; a requester keeps it high for
// as long as it wants the mux. gnt[i] answers one edge later and stays high
// until a release edge. done is a single-cycle level sampled only while a
// grant is active; dropping req[owner] has the same effect as done.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout,
  output arb_state_t       dbg_state_o
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  arb_state_t       state_q, state_d;
  sel_idx_t         ptr_q, ptr_d;
  sel_idx_t         owner_q, owner_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  sel_idx_t         sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  sel_idx_t         pick_idx;
  sel_idx_t         pick_ptr;
  logic             at_limit;
  logic             release_now;

  // While granting, the search starts just past the owner so the releasing
  // owner ranks last; while idle it starts at the stored pointer.
  assign pick_ptr = (state_q == GRANT) ? sel_idx_t'(owner_q + sel_idx_t'(1)) : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign at_limit    = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
  assign release_now = done || !req[owner_q] || at_limit;

  // State register and all registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic: grant from idle, hold/count, or release with handover.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = GRANT;
          owner_d     = pick_idx;
          sel_d       = pick_idx;
          gnt_d       = N_REQ'(1) << pick_idx;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = owner_q + sel_idx_t'(1);
          // Pulse only when the hold limit is the sole reason for release.
          timeout_d = at_limit && !done && req[owner_q];
          if (pick_any) begin
            owner_d     = pick_idx;
            sel_d       = pick_idx;
            gnt_d       = N_REQ'(1) << pick_idx;
            gnt_valid_d = 1'b1;
            hold_cnt_d  = '0;
          end else begin
            // sel keeps its last value so the mux output stays quiet.
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign gnt_valid   = gnt_valid_q;
  assign timeout     = timeout_q;
  assign dbg_state_o = state_q;

endmodule
